nav_button_conditioner: RTL
===========================

NAV_BUTTON_CONDITIONER -- requirements
Module: nav_button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the consecutive stable cycles required to accept a level change (10 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY, default 25000000, SHALL set the hold cycles before the first auto-repeat pulse.
REQ-003 Parameter REPEAT_RATE, default 7500000, SHALL set the cycles between subsequent auto-repeat pulses.
REQ-004 Parameter ACTIVE_LOW, default 1, SHALL mean raw buttons read 0 when pressed.
REQ-005 CLK  input  1  single system clock; all logic on its rising edge.
REQ-006 RST  input  1  reset, synchronous and active-high.
REQ-007 upButton, downButton, leftButton, rightButton  input  1 each  raw asynchronous board buttons.
REQ-008 upPulse, downPulse, leftPulse, rightPulse  output  1 each  registered one-cycle navigation commands to the interface controller.
REQ-009 anyHeld  output  1  registered; high while any debounced button is pressed.

Function
REQ-010 Each raw input SHALL pass a 2-flop synchronizer, then be normalised to active-high per ACTIVE_LOW.
REQ-011 Each button SHALL keep a debounced state that toggles only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; its counter clears on any cycle where they agree.
REQ-012 A press edge (debounced 0->1) SHALL produce one pulse on the matching output exactly DEBOUNCE_CYCLES+3 cycles after the first clock edge sampling the raw pressed level, given a stable raw input.
REQ-013 Release edges SHALL produce no pulse.
REQ-014 At most one pulse output SHALL be high in any cycle; simultaneous press edges resolve by priority up > down > left > right, lower-priority edges dropped.
REQ-015 Auto-repeat FSM states: IDLE, DELAY, REPEAT.
REQ-016 IDLE -> DELAY when a press pulse is issued and exactly one debounced button is pressed; repeat counter loads 0.
REQ-017 DELAY: after REPEAT_DELAY cycles SHALL pulse the held direction and enter REPEAT.
REQ-018 REPEAT: SHALL pulse the held direction every REPEAT_RATE cycles.
REQ-019 Any change of the 4-bit debounced vector in DELAY or REPEAT SHALL return to IDLE that cycle, with no repeat pulse; a simultaneous new press edge is handled per REQ-016 in the same cycle.
REQ-020 Counters SHALL be sized from parameters (clog2 of max+1); no wrap-around while counting.
REQ-021 anyHeld SHALL equal the OR of the debounced states, delayed one register.

Reset
REQ-022 With RST high at a clock edge: synchronizers and debounced states SHALL load the released level, all counters 0, FSM IDLE, all pulse outputs and anyHeld 0.
REQ-023 A button already pressed when RST deasserts SHALL produce a press pulse only after full debounce per REQ-012.
REQ-024 RST mid-repeat SHALL suppress any pulse in the reset cycle and the following cycle.

Structure
REQ-025 Direction index encoding (UP=0, DOWN=1, LEFT=2, RIGHT=3) and default timing constants SHALL live in the shared sudoku package.
REQ-026 Synchronizer plus debounce SHALL be a sub-module button_debouncer, instantiated four times; FSM, arbitration and pulse registers stay in the top module.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, ACTIVE_LOW=1)
REQ-027 upButton driven 0 and held; release after 10 cycles -> upPulse high for exactly 1 cycle, 7 cycles after first sampled 0; no other pulse.
REQ-028 leftButton bounces 0/1/0/1 on alternate cycles, then stable 0 -> no pulse during bounce; one leftPulse 7 cycles after stable 0 begins.
REQ-029 rightButton held 60 cycles after debounce -> pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52; none after release.
REQ-030 up and down pressed on the same cycle -> only upPulse issued; FSM stays IDLE, no repeats while both held.
REQ-031 downButton held into REPEAT; RST pulsed 1 cycle -> no pulses during reset and following cycle; all outputs 0; next downPulse 7 cycles after RST falls.
REQ-032 In REPEAT on up, press left -> repeats stop; leftPulse issued on left's debounce; left repeats resume only after up released and after the subsequent REPEAT_DELAY.

Source files
------------

// File: rtl/nav_button_conditioner_pkg.sv
// Shared definitions for the navigation button conditioner: direction index
// encoding, default timing constants, repeat FSM states and small vector helpers.
package nav_button_conditioner_pkg;

    localparam int NUM_BUTTONS = 4;

    // Default timing for a 50 MHz system clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;    // 10 ms
    localparam int DEFAULT_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int DEFAULT_REPEAT_RATE     = 7500000;   // 150 ms

    // Direction index; also the bit position inside every 4-bit button vector
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dirIdx_e;

    localparam int IDX_UP    = 0;
    localparam int IDX_DOWN  = 1;
    localparam int IDX_LEFT  = 2;
    localparam int IDX_RIGHT = 3;

    // Auto-repeat sequencer states
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rptState_e;

    // Number of set bits in a button vector
    function automatic logic [2:0] countHeld(input logic [3:0] vec);
        logic [2:0] total;
        total = 3'd0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            total = total + {2'b00, vec[i]};
        end
        return total;
    endfunction

    // Highest-priority direction present in a vector (up > down > left > right);
    // callers only use it on a non-empty vector
    function automatic dirIdx_e firstIndex(input logic [3:0] vec);
        dirIdx_e idx;
        if (vec[0]) begin
            idx = DIR_UP;
        end else if (vec[1]) begin
            idx = DIR_DOWN;
        end else if (vec[2]) begin
            idx = DIR_LEFT;
        end else begin
            idx = DIR_RIGHT;
        end
        return idx;
    endfunction

    // One-hot pulse vector for a direction
    function automatic logic [3:0] dirOneHot(input dirIdx_e dir);
        logic [3:0] hot;
        case (dir)
            DIR_UP:    hot = 4'b0001;
            DIR_DOWN:  hot = 4'b0010;
            DIR_LEFT:  hot = 4'b0100;
            DIR_RIGHT: hot = 4'b1000;
            default:   hot = 4'b0000;
        endcase
        return hot;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes one raw board button, normalises it to active-high and
// debounces it: the state flips only after DEBOUNCE_CYCLES consecutive
// cycles of disagreement with the synchronized level.
module button_debouncer
    import nav_button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic rawButton,
    output logic debounced
);

    localparam int              CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic            RELEASED_RAW = ACTIVE_LOW;

    logic             syncA_r;
    logic             syncB_r;
    logic             pressed_s;
    logic             debState_r;
    logic [CNT_W-1:0] count_r;

    // Two-flop synchronizer; reset parks it at the released raw level
    always_ff @(posedge CLK) begin
        if (RST) begin
            syncA_r <= RELEASED_RAW;
            syncB_r <= RELEASED_RAW;
        end else begin
            syncA_r <= rawButton;
            syncB_r <= syncA_r;
        end
    end

    // Normalise the synchronized level to pressed = 1
    always_comb begin
        if (ACTIVE_LOW) begin
            pressed_s = ~syncB_r;
        end else begin
            pressed_s = syncB_r;
        end
    end

    // Disagreement counter; toggles the debounced state on the last cycle of a full run
    always_ff @(posedge CLK) begin
        if (RST) begin
            debState_r <= 1'b0;
            count_r    <= {CNT_W{1'b0}};
        end else if (pressed_s == debState_r) begin
            count_r <= {CNT_W{1'b0}};
        end else if (count_r == CNT_LAST) begin
            debState_r <= ~debState_r;
            count_r    <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign debounced = debState_r;

endmodule

// File: rtl/nav_button_conditioner.sv
// Navigation button conditioner: four debounced buttons turned into one-cycle
// navigation pulses with press-edge priority arbitration and auto-repeat.
module nav_button_conditioner
    import nav_button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEFAULT_REPEAT_RATE,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic upButton,
    input  logic downButton,
    input  logic leftButton,
    input  logic rightButton,
    output logic upPulse,
    output logic downPulse,
    output logic leftPulse,
    output logic rightPulse,
    output logic anyHeld
);

    localparam int               RPT_MAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int               RPT_W      = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    logic [3:0]       rawVec_s;
    logic [3:0]       debState_s;
    logic [3:0]       debVec_r;
    logic [3:0]       debPrev_r;
    logic [3:0]       pressEdge_s;
    logic             changed_s;
    logic             singleHeld_s;
    logic [3:0]       nextPulse_s;
    logic [3:0]       pulse_r;
    logic             anyHeld_r;
    rptState_e        state_r;
    rptState_e        stateNext_s;
    logic [RPT_W-1:0] rptCount_r;
    logic [RPT_W-1:0] rptCountNext_s;
    dirIdx_e          heldDir_r;
    dirIdx_e          heldDirNext_s;

    assign rawVec_s = {rightButton, leftButton, downButton, upButton};

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : genDebounce
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) uDebouncer (
            .CLK       (CLK),
            .RST       (RST),
            .rawButton (rawVec_s[i]),
            .debounced (debState_s[i])
        );
    end

    // Register the debounced vector and its previous value for edge/change detection
    always_ff @(posedge CLK) begin
        if (RST) begin
            debVec_r  <= 4'b0000;
            debPrev_r <= 4'b0000;
            anyHeld_r <= 1'b0;
        end else begin
            debVec_r  <= debState_s;
            debPrev_r <= debVec_r;
            anyHeld_r <= |debState_s;
        end
    end

    // Press edges, vector change and single-button-held detection
    always_comb begin
        pressEdge_s  = debVec_r & ~debPrev_r;
        changed_s    = (debVec_r != debPrev_r);
        singleHeld_s = (countHeld(debVec_r) == 3'd1);
    end

    // Repeat FSM next state, repeat counter and pulse selection
    always_comb begin
        stateNext_s    = state_r;
        rptCountNext_s = rptCount_r;
        heldDirNext_s  = heldDir_r;
        nextPulse_s    = 4'b0000;

        // Only the highest-priority new press is reported; others are dropped
        if (pressEdge_s != 4'b0000) begin
            nextPulse_s = dirOneHot(firstIndex(pressEdge_s));
        end else begin
            nextPulse_s = 4'b0000;
        end

        if (changed_s) begin
            // Any change cancels a pending repeat; re-arm whenever the held set
            // settles to exactly one direction (new press or partner released)
            rptCountNext_s = {RPT_W{1'b0}};
            if (singleHeld_s) begin
                stateNext_s   = RPT_DELAY;
                heldDirNext_s = firstIndex(debVec_r);
            end else begin
                stateNext_s = RPT_IDLE;
            end
        end else begin
            case (state_r)
                RPT_IDLE: begin
                    stateNext_s = RPT_IDLE;
                end
                RPT_DELAY: begin
                    if (rptCount_r == DELAY_LAST) begin
                        nextPulse_s    = dirOneHot(heldDir_r);
                        stateNext_s    = RPT_REPEAT;
                        rptCountNext_s = {RPT_W{1'b0}};
                    end else begin
                        rptCountNext_s = rptCount_r + RPT_W'(1);
                    end
                end
                RPT_REPEAT: begin
                    if (rptCount_r == RATE_LAST) begin
                        nextPulse_s    = dirOneHot(heldDir_r);
                        rptCountNext_s = {RPT_W{1'b0}};
                    end else begin
                        rptCountNext_s = rptCount_r + RPT_W'(1);
                    end
                end
                default: begin
                    stateNext_s    = RPT_IDLE;
                    rptCountNext_s = {RPT_W{1'b0}};
                end
            endcase
        end
    end

    // FSM state, repeat counter, held direction and registered pulse outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= RPT_IDLE;
            rptCount_r <= {RPT_W{1'b0}};
            heldDir_r  <= DIR_UP;
            pulse_r    <= 4'b0000;
        end else begin
            state_r    <= stateNext_s;
            rptCount_r <= rptCountNext_s;
            heldDir_r  <= heldDirNext_s;
            pulse_r    <= nextPulse_s;
        end
    end

    assign upPulse    = pulse_r[IDX_UP];
    assign downPulse  = pulse_r[IDX_DOWN];
    assign leftPulse  = pulse_r[IDX_LEFT];
    assign rightPulse = pulse_r[IDX_RIGHT];
    assign anyHeld    = anyHeld_r;

endmodule
